// File: rtl/sb64_inv.sv
// Iterative inverse of the SB64 Feistel box: UNROLL inverse rounds per clock,
// walking the round constants from the highest index down to zero.
module sb64_inv #(
    parameter int ROUNDS = 8,
    parameter int UNROLL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [63:0]       x_in,
    input  logic [ROUNDS-1:0] rc,
    output logic [63:0]       x_out,
    output logic              valid,
    output logic              busy
);

    localparam int IDXW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    // state | meaning
    // IDLE  | waiting for start; result (if any) held on x_out
    // RUN   | applying UNROLL inverse rounds per cycle
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       l_q, r_q, l_d, r_d;
    logic [31:0]       l_chain, r_chain;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [ROUNDS-1:0] rc_q, rc_d;
    logic              valid_q, valid_d;
    logic              last_step;

    function automatic logic [31:0] f32(input logic [31:0] v);
        return ({v[26:0], v[31:27]} & v) ^ {v[30:0], v[31]};
    endfunction

    assign last_step = (idx_q == IDXW'(UNROLL - 1));

    // Indices below the chain length are only reached in IDLE, where the
    // chain output is discarded; the range guard keeps the bit select legal.
    always_comb begin
        logic [31:0]     tmp;
        logic [IDXW-1:0] idx_k;
        logic            cbit;
        tmp     = '0;
        idx_k   = '0;
        cbit    = 1'b0;
        l_chain = l_q;
        r_chain = r_q;
        for (int k = 0; k < UNROLL; k++) begin
            idx_k   = idx_q - IDXW'(k);
            cbit    = (int'(idx_k) < ROUNDS) ? rc_q[idx_k] : 1'b0;
            tmp     = r_chain;
            r_chain = l_chain ^ f32(r_chain) ^ {31'h7FFF_FFFF, cbit};
            l_chain = tmp;
        end
    end

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        idx_d   = idx_q;
        rc_d    = rc_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    l_d     = x_in[63:32];
                    r_d     = x_in[31:0];
                    rc_d    = rc;
                    idx_d   = IDXW'(ROUNDS - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                l_d = l_chain;
                r_d = r_chain;
                if (last_step) begin
                    // park the counter at zero rather than wrapping past it
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDXW'(UNROLL);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            l_q     <= '0;
            r_q     <= '0;
            idx_q   <= '0;
            rc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            rc_q    <= rc_d;
            valid_q <= valid_d;
        end
    end

    assign x_out = {l_q, r_q};
    assign valid = valid_q;
    assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_sb64_inv.sv
// Bench for sb64_inv: four instances (UNROLL 1/2/4/8) checked against a
// loop-based forward/inverse model; protocol cases exercise the UNROLL=4 one.
module tb_sb64_inv;

    logic        clk;
    logic        rst;
    logic [3:0]  start_v;
    logic [63:0] x_in;
    logic [7:0]  rc;
    logic [63:0] xo  [4];
    logic        vld [4];
    logic        bsy [4];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sb64_inv #(.ROUNDS(8), .UNROLL(1 << g)) dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_v[g]),
            .x_in  (x_in),
            .rc    (rc),
            .x_out (xo[g]),
            .valid (vld[g]),
            .busy  (bsy[g])
        );
    end

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] fm(input logic [31:0] v);
        return (rotl(v, 5) & v) ^ rotl(v, 1);
    endfunction

    function automatic logic [63:0] fwd_m(input logic [63:0] x, input logic [7:0] r);
        logic [31:0] l, rr, t;
        l = x[63:32]; rr = x[31:0];
        for (int i = 0; i < 8; i++) begin
            t  = l;
            l  = fm(l) ^ rr ^ (32'hFFFF_FFFE | 32'(r[i]));
            rr = t;
        end
        return {l, rr};
    endfunction

    function automatic logic [63:0] inv_m(input logic [63:0] x, input logic [7:0] r);
        logic [31:0] l, rr, t;
        l = x[63:32]; rr = x[31:0];
        for (int i = 7; i >= 0; i--) begin
            t  = rr;
            rr = l ^ fm(rr) ^ (32'hFFFF_FFFE | 32'(r[i]));
            l  = t;
        end
        return {l, rr};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch on all four instances and check latency, pulse count and value.
    task automatic run_all(input string name, input logic [63:0] y, input logic [7:0] r,
                           input logic [63:0] exp);
        int          lat [4];
        int          cnt [4];
        logic [63:0] got [4];
        for (int g = 0; g < 4; g++) begin lat[g] = -1; cnt[g] = 0; got[g] = '0; end
        x_in = y; rc = r; start_v = 4'hF;
        tick();
        start_v = 4'h0;
        rc = 8'($urandom);
        x_in = {$urandom, $urandom};
        for (int c = 1; c <= 10; c++) begin
            tick();
            for (int g = 0; g < 4; g++) begin
                if (vld[g]) begin cnt[g]++; lat[g] = c; got[g] = xo[g]; end
            end
        end
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("%s u%0d latency", name, 1 << g), 64'(lat[g]), 64'(8 >> g));
            chk($sformatf("%s u%0d pulses", name, 1 << g), 64'(cnt[g]), 64'd1);
            chk($sformatf("%s u%0d value", name, 1 << g), got[g], exp);
        end
    endtask

    task automatic start_u4(input logic [63:0] y, input logic [7:0] r);
        x_in = y; rc = r; start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
    endtask

    typedef struct {
        logic [63:0] y;
        logic [7:0]  r;
        logic [63:0] exp;
    } vec_t;

    initial begin
        vec_t        tv [3];
        logic [63:0] x1, x2, y;
        logic [7:0]  r1, r2;

        tv[0] = '{y: '0, r: 8'hA5, exp: 64'h0123_4567_89AB_CDEF};
        tv[1] = '{y: '0, r: 8'h00, exp: 64'h0123_4567_89AB_CDEF};
        tv[2] = '{y: '0, r: 8'hFF, exp: 64'h0123_4567_89AB_CDEF};
        for (int i = 0; i < 3; i++) tv[i].y = fwd_m(tv[i].exp, tv[i].r);

        rst = 1'b1; start_v = '0; x_in = '0; rc = '0;
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle valid", 64'(vld[2]), 64'd0);
            chk("idle busy", 64'(bsy[2]), 64'd0);
            chk("idle x_out", xo[2], 64'd0);
        end

        for (int i = 0; i < 3; i++) run_all($sformatf("vec%0d", i), tv[i].y, tv[i].r, tv[i].exp);

        for (int n = 0; n < 1000; n++) begin
            x1 = {$urandom, $urandom};
            r1 = 8'($urandom);
            run_all("rand", fwd_m(x1, r1), r1, x1);
        end

        // start pulsed during RUN is dropped
        x1 = 64'hDEAD_BEEF_1234_5678; r1 = 8'h5A;
        start_u4(fwd_m(x1, r1), r1);
        x_in = 64'h1111_2222_3333_4444; start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        tick();
        chk("ignore start valid", 64'(vld[2]), 64'd1);
        chk("ignore start value", xo[2], x1);
        tick();
        chk("ignore start not queued", 64'(bsy[2]), 64'd0);

        // rc changed mid-run
        x1 = 64'hCAFE_F00D_0BAD_F00D; r1 = 8'h96;
        start_u4(fwd_m(x1, r1), r1);
        rc = ~r1;
        tick(); tick();
        chk("rc change valid", 64'(vld[2]), 64'd1);
        chk("rc change value", xo[2], x1);

        // back-to-back: start taken in the valid cycle
        x1 = 64'h0F0F_0F0F_F0F0_F0F0; r1 = 8'h81;
        x2 = 64'h7654_3210_FEDC_BA98; r2 = 8'h42;
        start_u4(fwd_m(x1, r1), r1);
        tick(); tick();
        chk("b2b first valid", 64'(vld[2]), 64'd1);
        chk("b2b first value", xo[2], x1);
        start_u4(fwd_m(x2, r2), r2);
        chk("b2b reload busy", 64'(bsy[2]), 64'd1);
        chk("b2b reload valid", 64'(vld[2]), 64'd0);
        tick(); tick();
        chk("b2b second valid", 64'(vld[2]), 64'd1);
        chk("b2b second value", xo[2], x2);
        tick();

        // reset after the first compute edge aborts cleanly
        x1 = 64'h1357_9BDF_2468_ACE0; r1 = 8'h17;
        start_u4(fwd_m(x1, r1), r1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", 64'(bsy[2]), 64'd0);
        chk("abort valid", 64'(vld[2]), 64'd0);
        chk("abort x_out", xo[2], 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("abort no valid", 64'(vld[2]), 64'd0);
        end
        run_all("after abort", fwd_m(x1, r1), r1, x1);

        // forward box undoes the inverse
        x1 = 64'hFFFF_FFFF_0000_0000; r1 = 8'h3C;
        start_u4(x1, r1);
        tick(); tick();
        chk("inv-of-inv valid", 64'(vld[2]), 64'd1);
        y = xo[2];
        chk("inv-of-inv model", y, inv_m(x1, r1));
        chk("inv-of-inv fwd", fwd_m(y, r1), x1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sb64_inv.md
# sb64_inv

Inverse of the 64-bit Simeck-style SB64 box used in the sLiSCP/SPIX permutation datapath. It takes a 64-bit state that was produced by the forward SB64 transform with a given 8-bit round-constant vector and recovers the original input by running the Feistel rounds backwards, highest constant bit first. It is an iterative core with UNROLL rounds per clock and a start/valid handshake identical to the forward box. The decryption/verification paths and the forward-box self-check bench instantiate it.

## Interface

Parameters:
- ROUNDS, 8: total Feistel rounds; the rc width. Must be a multiple of UNROLL.
- UNROLL, 4: rounds evaluated per clock. Legal values are 1, 2, 4 and 8, subject to ROUNDS % UNROLL == 0.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- x_in  input  64  state to invert. {l, r} = {x_in[63:32], x_in[31:0]}.
- rc  input  ROUNDS  round-constant bits; rc[i] belongs to forward round i. Captured on start.
- x_out  output  64  {l, r} state register; holds the result after valid.
- valid  output  1  one-cycle pulse when x_out holds the finished result.
- busy  output  1  high while computing; start is ignored while high.

## Operation

- f(x) = (rotl(x,5) & x) ^ rotl(x,1), on 32 bits. C_i = 32'hFFFF_FFFE | rc[i], i.e. 31 ones followed by rc[i].
- Forward round i (reference only, not implemented here): (l, r) -> (f(l) ^ r ^ C_i, l), applied for i = 0..ROUNDS-1.
- Inverse round i (implemented): (l, r) -> (r, l ^ f(r) ^ C_i).
- Inverse rounds are applied for i = ROUNDS-1 down to 0.
- Each cycle a combinational chain of UNROLL inverse rounds uses indices idx, idx-1, …, idx-UNROLL+1.
- Down-counter idx is clog2(ROUNDS) bits wide. It is loaded with ROUNDS-1 on start and decremented by UNROLL per compute cycle. It must never underflow into a wrong index.
- rc is latched into an internal register on start. Later changes to rc do not affect the operation in flight.
- FSM:
  - IDLE: busy=0. On start=1, load l/r from x_in, latch rc, set idx=ROUNDS-1, go to RUN.
  - RUN: busy=1. Each cycle, state <= UNROLL inverse rounds of state and idx -= UNROLL.
  - On the last step (idx == UNROLL-1): valid <= 1, go to IDLE.
- valid defaults to 0 every cycle and is high only in the cycle after the final RUN edge.
- x_out is driven directly from the state register. It changes during RUN, holds after valid, and is overwritten on the next accepted start.
- start in RUN is ignored and not queued.
- start in the same cycle that valid is high is accepted, because the FSM is already in IDLE. Back-to-back operation therefore has no idle gap beyond the load cycle.
- Composition property: sb64_inv(SB64(x, rc), rc) == x and SB64(sb64_inv(y, rc), rc) == y, for all x, y, rc.

## Timing

- Reset values: valid=0, busy=0, x_out=64'h0, idx=0, latched rc=0, FSM=IDLE.
- rst has priority over start and over RUN. Asserting it mid-operation aborts in one cycle, produces no valid, and leaves busy=0 on the next cycle.
- Latency: start sampled at edge E0 (load). Compute edges are E1…EN, with N = ROUNDS/UNROLL.
- valid is high during the cycle after EN. With the defaults (N=2), valid is high 2 cycles after the load edge, i.e. 3 cycles after start is presented.
- busy rises after E0 and falls after EN, in the same cycle valid is high.
- Throughput: one result every N+1 cycles.
- Critical path: UNROLL cascaded (rotate, AND, XOR, XOR) stages. This is equal to the forward box at the same UNROLL.

## Test plan

- Reset then idle: assert rst for 2 cycles, then hold start=0 for 20 cycles. Required: valid=0, busy=0, x_out=0 throughout.
- Round-trip: x=64'h0123_4567_89AB_CDEF, rc=8'hA5, run through forward SB64, feed the result to sb64_inv with rc=8'hA5.
  - Required: valid pulses exactly once, 2 cycles after the load edge.
  - Required: x_out=64'h0123_4567_89AB_CDEF.
  - Repeat with rc=8'h00 and rc=8'hFF.
- Golden model: run 1000 random (x_in, rc) pairs, checking x_out against a software inverse model at the valid edge. Repeat with UNROLL = 1, 2, 4 and 8; valid latency must be 8, 4, 2 and 1 compute cycles respectively.
- Protocol:
  - Pulse start again during RUN with a different x_in. Required: it is ignored and the result matches the first input.
  - Change rc mid-RUN. Required: the result is unchanged.
  - Assert start in the valid cycle. Required: the next result follows with no lost cycle.
- Reset mid-op: assert rst on the cycle after the first compute edge. Required: no valid pulse, busy=0 on the next cycle, and a following start produces a correct result.
- Inverse-of-inverse: compute y = sb64_inv(x, rc), then apply forward SB64 to y with the same rc. Required: the result equals x for x=64'hFFFF_FFFF_0000_0000 and rc=8'h3C.
